gray_checker: RTL and testbench
===============================

// Module: gray_checker
// PURPOSE
//   Receive-side companion to the Gray-code counter: samples a WIDTH-bit Gray
//   stream, converts each sample to binary and checks it is the exact successor
//   (+1 mod 2^WIDTH) of the previous accepted sample.
//   Sits downstream of a Gray counter or synchroniser. Reports decoded value,
//   wrap events and sequence errors. Tracks an error count.
// PARAMETERS
//   WIDTH  3  Gray/binary word width (>=2)
//   ERR_W  8  Err_cnt width; counter saturates at 2^ERR_W-1
// PORTS
//   Clk         in   1        rising-edge clock
//   Reset_n     in   1        asynchronous, active-low reset
//   Clear       in   1        synchronous resync: return to SYNC, keep Err_cnt
//   En          in   1        Gray_in valid this cycle
//   Gray_in     in   WIDTH    Gray-coded sample
//   Binary      out  WIDTH    decoded value of last accepted sample (registered)
//   Valid_out   out  1        1-cycle pulse: Binary updated this cycle
//   Step_err    out  1        1-cycle pulse: accepted sample was not prev+1
//   Wrap        out  1        1-cycle pulse: step all-ones -> zero accepted
//   Wrap_seen   out  1        sticky Wrap; cleared by reset or Clear
//   Locked      out  1        1 while FSM in LOCKED
//   Err_cnt     out  ERR_W    saturating count of Step_err pulses
// BEHAVIOUR
//   Reset (Reset_n=0, async): all outputs 0, state SYNC.
//   Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]; pure combinational on Gray_in.
//   All outputs registered: sample on edge N -> outputs valid after edge N.
//   Pulses (Valid_out, Step_err, Wrap) are high exactly one cycle; 0 when En=0.
//   FSM (2 states):
//     SYNC:   En=1 -> Binary<=b, Valid_out=1, no check, -> LOCKED.
//     LOCKED: En=1 and b==Binary     -> repeat/stall: no pulses, no update.
//             En=1 and b==Binary+1   -> Binary<=b, Valid_out=1; if Binary was
//                                       all-ones (b==0): Wrap=1, Wrap_seen<=1.
//             En=1, any other b      -> Binary<=b, Valid_out=1, Step_err=1,
//                                       Err_cnt+=1 (saturating), -> SYNC.
//   Step error drops to SYNC: the next accepted sample is re-referenced unchecked.
//   Binary+1 is computed modulo 2^WIDTH (carry discarded).
//   Clear=1: -> SYNC, Wrap_seen<=0, pulses 0; Binary and Err_cnt hold.
//     Clear with En same cycle: Clear wins, sample discarded.
//   Err_cnt at 2^ERR_W-1 stays there; Step_err still pulses.
//   Reset_n asserted mid-stream: immediate return to reset values, no partial
//     update on following edge.
// CONFIGURATION
//   GRAY_CHECK_ERRCNT_EN defined: Err_cnt implemented as above.
//   Not defined: Err_cnt tied to 0, no counter flops; Step_err, FSM unchanged.
// TESTING (WIDTH=3; Gray seq 000,001,011,010,110,111,101,100)
//   Reset then Gray 000..100 with En=1 each cycle -> Binary 0..7, Valid_out
//     every cycle, Locked from cycle 2, Step_err=0.
//   Continue 100 -> 000 -> Wrap=1 one cycle, Binary=0, Wrap_seen=1 stays set.
//   LOCKED at Binary=2 (011), feed 111 (b=5) -> Step_err=1, Binary=5, Err_cnt=1,
//     Locked=0; next 101 (b=6) accepted unchecked, Locked=1.
//   Repeat 010 twice with En=1, then En=0 gaps -> no pulses, Binary=3 held.
//   Clear and En same cycle, then Reset_n low mid-cycle -> sample ignored,
//     Wrap_seen=0; all outputs 0 without a clock edge.
//   With GRAY_CHECK_ERRCNT_EN, 260 forced errors (ERR_W=8) -> Err_cnt=255;
//     without the macro Err_cnt=0 throughout.

Source files
------------

// File: rtl/gray_checker_if.sv
// gray_checker_if: sample stream into the Gray checker plus its status outputs.
//
// Handshake: En is a valid-only qualifier. Gray_in is meaningful only in a
// cycle where En=1. There is no ready; the checker takes every valid sample
// on the rising edge of Clk. Valid_out is the matching output-side valid: a
// one-cycle pulse marking the cycle in which Binary took a new value.
interface gray_checker_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
);
  logic             En;
  logic [WIDTH-1:0] Gray_in;
  logic [WIDTH-1:0] Binary;
  logic             Valid_out;
  logic             Step_err;
  logic             Wrap;
  logic             Wrap_seen;
  logic             Locked;
  logic [ERR_W-1:0] Err_cnt;
  logic             Dbg_state;

  // The sample source and observer side.
  modport master (
    output En,
    output Gray_in,
    input  Binary,
    input  Valid_out,
    input  Step_err,
    input  Wrap,
    input  Wrap_seen,
    input  Locked,
    input  Err_cnt,
    input  Dbg_state
  );

  // The checker side.
  modport slave (
    input  En,
    input  Gray_in,
    output Binary,
    output Valid_out,
    output Step_err,
    output Wrap,
    output Wrap_seen,
    output Locked,
    output Err_cnt,
    output Dbg_state
  );
endinterface

// File: rtl/gray_checker.sv
// gray_checker: receive-side checker for a Gray-code counter stream.
// Decodes each accepted Gray sample to binary and checks that it is the
// exact successor (+1 mod 2^WIDTH) of the previously accepted value.
// Optional feature macro: GRAY_CHECK_ERRCNT_EN enables the saturating
// step-error counter on Err_cnt; without it Err_cnt is tied to zero.
module gray_checker #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Clear,
  gray_checker_if.slave bus
);

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] binary_inc;
  logic             take;
  logic             is_repeat;
  logic             is_succ;
  logic             step_hit;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    r[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  // Classify the incoming sample against the last accepted value.
  always_comb begin
    b_in       = gray2bin(bus.Gray_in);
    binary_inc = bus.Binary + WIDTH'(1);
    take       = bus.En && !Clear;
    is_repeat  = (b_in == bus.Binary);
    is_succ    = (b_in == binary_inc);
    step_hit   = take && (state == LOCKED) && !is_repeat && !is_succ;
  end

  // Sequence FSM with registered value, pulses and sticky wrap flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= SYNC;
      bus.Binary    <= '0;
      bus.Valid_out <= 1'b0;
      bus.Step_err  <= 1'b0;
      bus.Wrap      <= 1'b0;
      bus.Wrap_seen <= 1'b0;
    end else begin
      bus.Valid_out <= 1'b0;
      bus.Step_err  <= 1'b0;
      bus.Wrap      <= 1'b0;
      if (Clear) begin
        // Resync request: drop lock and the wrap history, keep the value.
        state         <= SYNC;
        bus.Wrap_seen <= 1'b0;
      end else if (take) begin
        case (state)
          SYNC: begin
            // First sample after reset/resync is taken as the new reference.
            bus.Binary    <= b_in;
            bus.Valid_out <= 1'b1;
            state         <= LOCKED;
          end
          LOCKED: begin
            if (is_repeat) begin
              // Source stalled on the same code: nothing to report.
              state <= LOCKED;
            end else if (is_succ) begin
              bus.Binary    <= b_in;
              bus.Valid_out <= 1'b1;
              if (bus.Binary == ALL_ONES) begin
                bus.Wrap      <= 1'b1;
                bus.Wrap_seen <= 1'b1;
              end
            end else if (step_hit) begin
              // Broken sequence: report, adopt the value, re-reference next.
              bus.Binary    <= b_in;
              bus.Valid_out <= 1'b1;
              bus.Step_err  <= 1'b1;
              state         <= SYNC;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  assign bus.Locked    = (state == LOCKED);
  assign bus.Dbg_state = state;

`ifdef GRAY_CHECK_ERRCNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Saturating count of step errors; only reset clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.Err_cnt <= '0;
    end else if (step_hit && (bus.Err_cnt != ERR_MAX)) begin
      bus.Err_cnt <= bus.Err_cnt + ERR_W'(1);
    end
  end
`else
  assign bus.Err_cnt = '0;
`endif

endmodule

// File: tb/tb_gray_checker.sv
// tb_gray_checker: scoreboard bench for gray_checker (WIDTH=3, ERR_W=8).
module tb_gray_checker;
  localparam int WIDTH = 3;
  localparam int ERR_W = 8;
  localparam int EXP_W = WIDTH + 6 + ERR_W;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n;
  logic Clear;
  always #5 Clk = ~Clk;

  gray_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  gray_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clear   (Clear),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EXP_W-1:0] exp_q[$];

  logic             m_locked;
  logic [WIDTH-1:0] m_bin;
  logic             m_wrap_seen;
  int               m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    r = g;
    for (int s = 1; s < WIDTH; s++) r = r ^ (g >> s);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ERR_W-1:0] exp_err();
`ifdef GRAY_CHECK_ERRCNT_EN
    return ERR_W'(m_err);
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_locked    = 1'b0;
    m_bin       = '0;
    m_wrap_seen = 1'b0;
    m_err       = 0;
    exp_q.delete();
  endtask

  // Advance the reference model by one clock and queue the expected outputs.
  task automatic model_step(input logic en, input logic clr, input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    logic v, se, wr;
    v = 1'b0; se = 1'b0; wr = 1'b0;
    b = g2b(g);
    if (clr) begin
      m_locked    = 1'b0;
      m_wrap_seen = 1'b0;
    end else if (en) begin
      if (!m_locked) begin
        m_bin = b; v = 1'b1; m_locked = 1'b1;
      end else if (b == m_bin) begin
        v = 1'b0;
      end else if (b == WIDTH'(m_bin + 1)) begin
        wr = (m_bin == {WIDTH{1'b1}});
        if (wr) m_wrap_seen = 1'b1;
        m_bin = b; v = 1'b1;
      end else begin
        m_bin = b; v = 1'b1; se = 1'b1; m_locked = 1'b0;
        if (m_err < ERR_MAX) m_err++;
      end
    end
    exp_q.push_back({m_bin, v, se, wr, m_wrap_seen, m_locked, m_locked, exp_err()});
  endtask

  task automatic compare_out();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    check("binary",    32'(bus.Binary),    32'(e[EXP_W-1 -: WIDTH]));
    check("valid_out", 32'(bus.Valid_out), 32'(e[ERR_W+5]));
    check("step_err",  32'(bus.Step_err),  32'(e[ERR_W+4]));
    check("wrap",      32'(bus.Wrap),      32'(e[ERR_W+3]));
    check("wrap_seen", 32'(bus.Wrap_seen), 32'(e[ERR_W+2]));
    check("locked",    32'(bus.Locked),    32'(e[ERR_W+1]));
    check("dbg_state", 32'(bus.Dbg_state), 32'(e[ERR_W]));
    check("err_cnt",   32'(bus.Err_cnt),   32'(e[ERR_W-1:0]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic clr, input logic [WIDTH-1:0] g);
    @(negedge Clk);
    bus.En      = en;
    Clear       = clr;
    bus.Gray_in = g;
    model_step(en, clr, g);
    @(posedge Clk);
    #1;
    compare_out();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_binary"}, 32'(bus.Binary), 32'd0);
    check({tag, "_valid"},  32'(bus.Valid_out), 32'd0);
    check({tag, "_serr"},   32'(bus.Step_err), 32'd0);
    check({tag, "_wrap"},   32'(bus.Wrap), 32'd0);
    check({tag, "_wseen"},  32'(bus.Wrap_seen), 32'd0);
    check({tag, "_locked"}, 32'(bus.Locked), 32'd0);
    check({tag, "_errcnt"}, 32'(bus.Err_cnt), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n     = 1'b0;
    bus.En      = 1'b0;
    Clear       = 1'b0;
    bus.Gray_in = '0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] g;
    Reset_n     = 1'b0;
    bus.En      = 1'b0;
    Clear       = 1'b0;
    bus.Gray_in = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Full Gray cycle 000..100, then wrap back to 000.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, b2g(WIDTH'(i)));
    step(1'b1, 1'b0, 3'b000);
    check("wrap_binary", 32'(bus.Binary), 32'd0);
    check("wrap_pulse",  32'(bus.Wrap), 32'd1);
    step(1'b0, 1'b0, 3'b000);
    check("wrap_sticky", 32'(bus.Wrap_seen), 32'd1);

    // Lock at 2, then jump to 5: step error, then 6 re-referenced.
    step(1'b1, 1'b0, 3'b001);
    step(1'b1, 1'b0, 3'b011);
    step(1'b1, 1'b0, 3'b111);
    check("jump_binary", 32'(bus.Binary), 32'd5);
    check("jump_serr",   32'(bus.Step_err), 32'd1);
    check("jump_locked", 32'(bus.Locked), 32'd0);
`ifdef GRAY_CHECK_ERRCNT_EN
    check("jump_errcnt", 32'(bus.Err_cnt), 32'd1);
`else
    check("jump_errcnt", 32'(bus.Err_cnt), 32'd0);
`endif
    step(1'b1, 1'b0, 3'b101);
    check("resync_locked", 32'(bus.Locked), 32'd1);
    check("resync_serr",   32'(bus.Step_err), 32'd0);

    // Get locked at 3, then repeats and idle gaps.
    step(1'b1, 1'b0, 3'b010);
    step(1'b1, 1'b0, 3'b010);
    step(1'b1, 1'b0, 3'b010);
    step(1'b1, 1'b0, 3'b010);
    step(1'b0, 1'b0, 3'b110);
    step(1'b0, 1'b0, 3'b111);
    check("hold_binary", 32'(bus.Binary), 32'd3);
    check("hold_valid",  32'(bus.Valid_out), 32'd0);

    // Clear with a sample in the same cycle: sample ignored.
    step(1'b1, 1'b1, 3'b110);
    check("clear_binary", 32'(bus.Binary), 32'd3);
    check("clear_wseen",  32'(bus.Wrap_seen), 32'd0);

    // Async reset in the middle of a cycle, then hold it across an edge.
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    bus.En      = 1'b1;
    bus.Gray_in = 3'b011;
    @(posedge Clk);
    #1;
    check_all_zero("held_rst");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Random stream, biased towards correct successors and stalls.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       g = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        1:       g = b2g(m_bin);
        default: g = b2g(WIDTH'(m_bin + 1));
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, g);
    end

    // Saturation: 260 forced errors from a clean reset.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 3'b000);
      step(1'b1, 1'b0, 3'b011);
    end
`ifdef GRAY_CHECK_ERRCNT_EN
    check("sat_errcnt", 32'(bus.Err_cnt), 32'(ERR_MAX));
`else
    check("sat_errcnt", 32'(bus.Err_cnt), 32'd0);
`endif
    check("sat_serr", 32'(bus.Step_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
